frame_collision_checker: RTL
============================

# frame_collision_checker

Once-per-frame collision and scoring engine for the Flappy game. It samples the bird position and the four pipe edges on a frame strobe, walks the pipes sequentially one per clock, and decides floor/ceiling/pipe collision. It produces a sticky lose flag and a pass-counting score. It sits between the position producers (flight_physics, X_RAM_NOREAD, Y_ROM) and the top-level VGA/SSD logic, which consumes Lose and Score.

## Interface
Parameters:
- BIRD_HALF, 10: half-size of the square bird box in pixels.
- PIPE_W, 80: pipe width in pixels.
- FLOOR_Y, 479: lowest legal pixel row; bird bottom ≥ FLOOR_Y is a collision.
- X_MAX, 639: rightmost pixel column, used as the clamp value.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- Scan_Start  in  1  single-cycle frame strobe; a scan begins when it is seen in IDLE.
- Ack  in  1  clears the LOST state.
- Run  in  1  enables score counting; collision checking runs regardless.
- Bird_X, Bird_Y  in  10 each  bird centre, unsigned.
- X_Edge0..X_Edge3  in  10 each  pipe left edges.
- Gap_T0..Gap_T3  in  10 each  top row of each pipe gap; pipe is solid for y < Gap_T.
- Gap_B0..Gap_B3  in  10 each  bottom row of each pipe gap; pipe is solid for y > Gap_B.
- Busy  out  1  high while a scan is in progress.
- Done  out  1  one-cycle pulse when a scan completes.
- Collide  out  1  result of the last scan, held until the next Done.
- Lose  out  1  sticky lose flag.
- Score  out  8  pipes passed; saturates at 255.

## Operation
- States: IDLE, CHECK, REPORT, LOST. Pipe index is a 2-bit counter `idx`.
- IDLE, on Scan_Start: latch all data inputs into shadow registers, compute the bird box, set idx=0, go to CHECK. The scan uses only the shadow copies; input changes during a scan are ignored.
- Bird box arithmetic is done in 11 bits. Each edge is clamped:
  - L = (X < BIRD_HALF) ? 0 : X−BIRD_HALF
  - R = min(X+BIRD_HALF, X_MAX)
  - T = (Y < BIRD_HALF) ? 0 : Y−BIRD_HALF
  - B = min(Y+BIRD_HALF, FLOOR_Y)
- Boundary hit: flagged when Y < BIRD_HALF (ceiling) or Y+BIRD_HALF ≥ FLOOR_Y (floor), computed in 11 bits.
- CHECK, one pipe per cycle, idx 0→3:
  - Pipe right edge PR = min(X_Edge+PIPE_W−1, X_MAX), computed in 11 bits.
  - X overlap: L ≤ PR and R ≥ X_Edge.
  - Hit for this pipe: X overlap and (T < Gap_T or B > Gap_B).
  - Hits are ORed into an accumulator. After idx=3, go to REPORT.
- Pass tracking: each pipe has a flag passed[i].
  - If PR < L and passed[i]=0: set passed[i]; add 1 to the increment count.
  - If PR ≥ L: clear passed[i]. This re-arms the flag when the pipe is recycled to the right.
- REPORT, one cycle:
  - Done=1; Collide = accumulator | boundary hit.
  - If Run=1, Score += increment count, saturating at 255.
  - If the collision result is 1: Lose=1, go to LOST. Otherwise go to IDLE.
  - Score still updates on the colliding frame.
- LOST: Scan_Start is ignored and Lose is held. Ack → IDLE with Lose=0, Score=0, passed=0, Collide=0.
- Ack outside LOST is ignored. Scan_Start outside IDLE is ignored, so there is no queueing.
- Reset takes priority over everything, including a scan in progress:
  - State = IDLE, idx=0.
  - Busy, Done, Collide, Lose = 0; Score = 0; passed = 0; shadow registers = 0.

## Timing
- Cycle 0: Scan_Start is sampled in IDLE.
- Cycles 1–4: CHECK pipes 0..3; Busy=1.
- Cycle 5: REPORT; Done=1, Busy=1.
- Collide, Lose and Score take their new values on the same edge that raises Done.
- Next accepted Scan_Start: earliest at cycle 6. Back-to-back frames therefore need at least 6 clocks between strobes.
- Busy falls at cycle 6 (IDLE) or stays low in LOST.
- Ack in LOST takes effect on the next edge. Scan_Start arriving on that same edge is ignored.

## Test plan
- Reset mid-scan: assert reset at cycle 3 of a scan → next cycle Busy=0, Done=0, Lose=0, Score=0; no Done pulse follows.
- Clear pass: bird (100,240); pipe0 X=95 with gap 200..300; other pipes at X=600 with gap 0..479 → Done at cycle 5, Collide=0, Lose=0, Score unchanged.
- Top-pipe hit: as above but Gap_T0=240 → Collide=1, Lose=1, state LOST. A subsequent Scan_Start gives no Busy; Ack clears Lose and Score.
- Floor and ceiling: Bird_Y=470 → Collide=1 (470+10 ≥ 479). Bird_Y=5 → Collide=1 with T clamped to 0, no wrap.
- Scoring: Run=1, pipe0 X=0 (PR=79 < L=90) → Score 0→1. Same inputs next frame → Score stays 1. X=500 then X=0 again → Score=2. Run=0 → no increment. Preload near 255 → stays 255.
- Right-edge clamp: X_Edge=600 gives PR=639, no wrap. Bird_X=635 gives R=639. A Scan_Start pulsed during Busy is ignored, and exactly one Done occurs.

Source files
------------

// File: rtl/frame_collision_checker_if.sv
// Frame-strobe, bird/pipe geometry and result bundle
// for the collision and scoring engine.
interface frame_collision_checker_if;
    logic       Scan_Start;
    logic       Ack;
    logic       Run;
    logic [9:0] Bird_X;
    logic [9:0] Bird_Y;
    logic [9:0] X_Edge0;
    logic [9:0] X_Edge1;
    logic [9:0] X_Edge2;
    logic [9:0] X_Edge3;
    logic [9:0] Gap_T0;
    logic [9:0] Gap_T1;
    logic [9:0] Gap_T2;
    logic [9:0] Gap_T3;
    logic [9:0] Gap_B0;
    logic [9:0] Gap_B1;
    logic [9:0] Gap_B2;
    logic [9:0] Gap_B3;
    logic       Busy;
    logic       Done;
    logic       Collide;
    logic       Lose;
    logic [7:0] Score;

    modport master (
        output Scan_Start, Ack, Run,
        output Bird_X, Bird_Y,
        output X_Edge0, X_Edge1, X_Edge2, X_Edge3,
        output Gap_T0, Gap_T1, Gap_T2, Gap_T3,
        output Gap_B0, Gap_B1, Gap_B2, Gap_B3,
        input  Busy, Done, Collide, Lose, Score
    );

    modport slave (
        input  Scan_Start, Ack, Run,
        input  Bird_X, Bird_Y,
        input  X_Edge0, X_Edge1, X_Edge2, X_Edge3,
        input  Gap_T0, Gap_T1, Gap_T2, Gap_T3,
        input  Gap_B0, Gap_B1, Gap_B2, Gap_B3,
        output Busy, Done, Collide, Lose, Score
    );
endinterface

// File: rtl/frame_collision_checker.sv
// Once-per-frame collision/score engine: walks the
// four pipes one per clock against a latched bird box.
module frame_collision_checker #(
    parameter int BIRD_HALF = 10,
    parameter int PIPE_W    = 80,
    parameter int FLOOR_Y   = 479,
    parameter int X_MAX     = 639
) (
    input logic                       clk,
    input logic                       reset,
    frame_collision_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REPORT,
        LOST
    } state_t;

    localparam logic [10:0] HALF  = 11'(BIRD_HALF);
    localparam logic [10:0] PW_M1 = 11'(PIPE_W - 1);
    localparam logic [10:0] FLOOR = 11'(FLOOR_Y);
    localparam logic [10:0] XMAX  = 11'(X_MAX);

    state_t state, state_d;
    logic [1:0] idx, idx_d;

    logic [3:0][9:0] sh_xe, sh_xe_d;
    logic [3:0][9:0] sh_gt, sh_gt_d;
    logic [3:0][9:0] sh_gb, sh_gb_d;
    logic [10:0] box_l, box_l_d;
    logic [10:0] box_r, box_r_d;
    logic [10:0] box_t, box_t_d;
    logic [10:0] box_b, box_b_d;
    logic        bnd, bnd_d;

    logic       acc, acc_d;
    logic [2:0] inc, inc_d;
    logic [3:0] passed, passed_d;
    logic       done_q, done_d;
    logic       col_q, col_d;
    logic       lose_q, lose_d;
    logic [7:0] score_q, score_d;

    logic [3:0][9:0] in_xe, in_gt, in_gb;
    logic [10:0] x11, y11, xr, yb;
    logic [10:0] xe, gt, gb, pr_raw, pr;
    logic        ovl, hit, pass_now, col_tot;
    logic [2:0]  inc_tot;
    logic [8:0]  sum;

    assign in_xe = {bus.X_Edge3, bus.X_Edge2,
                    bus.X_Edge1, bus.X_Edge0};
    assign in_gt = {bus.Gap_T3, bus.Gap_T2,
                    bus.Gap_T1, bus.Gap_T0};
    assign in_gb = {bus.Gap_B3, bus.Gap_B2,
                    bus.Gap_B1, bus.Gap_B0};

    assign x11 = {1'b0, bus.Bird_X};
    assign y11 = {1'b0, bus.Bird_Y};
    assign xr  = x11 + HALF;
    assign yb  = y11 + HALF;

    // Current pipe, selected from the shadow copies.
    assign xe     = {1'b0, sh_xe[idx]};
    assign gt     = {1'b0, sh_gt[idx]};
    assign gb     = {1'b0, sh_gb[idx]};
    assign pr_raw = xe + PW_M1;
    assign pr     = (pr_raw > XMAX) ? XMAX : pr_raw;

    assign ovl = (box_l <= pr) && (box_r >= xe);
    assign hit = ovl && ((box_t < gt) || (box_b > gb));
    assign pass_now = (pr < box_l) && !passed[idx];

    assign inc_tot = inc + {2'b00, pass_now};
    assign col_tot = acc | hit | bnd;
    assign sum     = {1'b0, score_q} + {6'd0, inc_tot};

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        sh_xe_d  = sh_xe;
        sh_gt_d  = sh_gt;
        sh_gb_d  = sh_gb;
        box_l_d  = box_l;
        box_r_d  = box_r;
        box_t_d  = box_t;
        box_b_d  = box_b;
        bnd_d    = bnd;
        acc_d    = acc;
        inc_d    = inc;
        passed_d = passed;
        done_d   = 1'b0;
        col_d    = col_q;
        lose_d   = lose_q;
        score_d  = score_q;
        unique case (state)
            IDLE: begin
                if (bus.Scan_Start) begin
                    sh_xe_d = in_xe;
                    sh_gt_d = in_gt;
                    sh_gb_d = in_gb;
                    box_l_d = (x11 < HALF) ? 11'd0 : x11 - HALF;
                    box_r_d = (xr > XMAX) ? XMAX : xr;
                    box_t_d = (y11 < HALF) ? 11'd0 : y11 - HALF;
                    box_b_d = (yb > FLOOR) ? FLOOR : yb;
                    bnd_d   = (y11 < HALF) || (yb >= FLOOR);
                    idx_d   = 2'd0;
                    acc_d   = 1'b0;
                    inc_d   = 3'd0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                acc_d = acc | hit;
                inc_d = inc_tot;
                if (pr < box_l) passed_d[idx] = 1'b1;
                else            passed_d[idx] = 1'b0;
                idx_d = idx + 2'd1;
                // Results land on the edge that raises Done.
                if (idx == 2'd3) begin
                    state_d = REPORT;
                    done_d  = 1'b1;
                    col_d   = col_tot;
                    if (bus.Run)
                        score_d = sum[8] ? 8'hFF : sum[7:0];
                    if (col_tot) lose_d = 1'b1;
                end
            end
            REPORT: begin
                state_d = lose_q ? LOST : IDLE;
            end
            LOST: begin
                if (bus.Ack) begin
                    state_d  = IDLE;
                    lose_d   = 1'b0;
                    score_d  = 8'd0;
                    passed_d = 4'd0;
                    col_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 2'd0;
            sh_xe  <= '0;
            sh_gt  <= '0;
            sh_gb  <= '0;
            box_l  <= '0;
            box_r  <= '0;
            box_t  <= '0;
            box_b  <= '0;
            bnd    <= 1'b0;
            acc    <= 1'b0;
            inc    <= 3'd0;
            passed <= 4'd0;
            done_q <= 1'b0;
            col_q  <= 1'b0;
            lose_q <= 1'b0;
            score_q <= 8'd0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            sh_xe  <= sh_xe_d;
            sh_gt  <= sh_gt_d;
            sh_gb  <= sh_gb_d;
            box_l  <= box_l_d;
            box_r  <= box_r_d;
            box_t  <= box_t_d;
            box_b  <= box_b_d;
            bnd    <= bnd_d;
            acc    <= acc_d;
            inc    <= inc_d;
            passed <= passed_d;
            done_q <= done_d;
            col_q  <= col_d;
            lose_q <= lose_d;
            score_q <= score_d;
        end
    end

    assign bus.Busy    = (state == CHECK) || (state == REPORT);
    assign bus.Done    = done_q;
    assign bus.Collide = col_q;
    assign bus.Lose    = lose_q;
    assign bus.Score   = score_q;
endmodule
